// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode behind a valid/ready handshake, with a
// load-use interlock and optional branch-shadow squashing (enabled by DECODE_BR_SQUASH_EN).
module decode_stage #(
  parameter int IW         = 32,
  parameter int OPW        = 5,
  parameter int RA_W       = 4,
  parameter int CW         = 16,
  parameter int LD_BUBBLES = 1,
  parameter int BR_SHADOW  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            data_sel,
  output logic            const_sel,
  output logic            load_en,
  output logic            offset_sel,
  output logic            J,
  output logic            write_en,
  output logic            illegal,
  output logic [CW-1:0]   const_in,
  output logic [RA_W-1:0] dest_sel,
  output logic [RA_W-1:0] A_sel,
  output logic [RA_W-1:0] B_sel,
  output logic [3:0]      op_sel,
  output logic [1:0]      mode_sel
);

  localparam int DEST_MSB = IW - OPW - 1;
  localparam int A_MSB    = DEST_MSB - RA_W;
  localparam int B_MSB    = A_MSB - RA_W;
  localparam int CNT_W    = (LD_BUBBLES > 1) ? $clog2(LD_BUBBLES + 1) : 1;

  typedef struct packed {
    logic            data_sel;
    logic            const_sel;
    logic            load_en;
    logic            offset_sel;
    logic            j;
    logic            write_en;
    logic            illegal;
    logic [CW-1:0]   const_in;
    logic [RA_W-1:0] dest_sel;
    logic [RA_W-1:0] a_sel;
    logic [RA_W-1:0] b_sel;
    logic [3:0]      op_sel;
    logic [1:0]      mode_sel;
  } bundle_t;

  function automatic bundle_t decode(input logic [IW-1:0] w);
    bundle_t b;
    logic [CW-1:0] imm;
    imm        = w[B_MSB -: CW];
    b          = '0;
    b.dest_sel = w[DEST_MSB -: RA_W];
    b.a_sel    = w[A_MSB -: RA_W];
    b.b_sel    = w[B_MSB -: RA_W];
    case (w[IW-1 -: OPW])
      OPW'(0):  ;
      OPW'(1):  begin b.load_en = 1'b1; b.const_sel = 1'b1; b.op_sel = 4'd5; end
      OPW'(2):  begin b.load_en = 1'b1; b.op_sel = 4'd0; end
      OPW'(3):  begin b.load_en = 1'b1; b.op_sel = 4'd1; end
      OPW'(4):  begin b.load_en = 1'b1; b.op_sel = 4'd4; end
      OPW'(5):  begin b.load_en = 1'b1; b.op_sel = 4'd5; end
      OPW'(6):  begin b.load_en = 1'b1; b.op_sel = 4'd6; end
      OPW'(7):  begin b.load_en = 1'b1; b.op_sel = 4'd7; end
      OPW'(8), OPW'(9), OPW'(10), OPW'(11), OPW'(12): begin
        b.load_en   = 1'b1;
        b.const_sel = 1'b1;
        b.b_sel     = '0;
        b.const_in  = imm;
        case (w[IW-1 -: OPW])
          OPW'(8):  b.op_sel = 4'd0;
          OPW'(9):  b.op_sel = 4'd1;
          OPW'(10): b.op_sel = 4'd4;
          OPW'(11): b.op_sel = 4'd5;
          default:  b.op_sel = 4'd6;
        endcase
      end
      OPW'(13): begin
        b.load_en = 1'b1; b.const_sel = 1'b1; b.b_sel = w[DEST_MSB -: RA_W]; b.op_sel = 4'd5;
      end
      OPW'(14): begin b.load_en = 1'b1; b.op_sel = 4'd9; end
      OPW'(15): begin b.load_en = 1'b1; b.op_sel = 4'd8; end
      OPW'(16): begin b.load_en = 1'b1; b.data_sel = 1'b1; b.b_sel = '0; end
      OPW'(17): begin b.write_en = 1'b1; b.dest_sel = '0; end
      OPW'(18): begin
        b.j = 1'b1; b.mode_sel = 2'd3; b.offset_sel = 1'b1; b.dest_sel = '0; b.b_sel = '0;
      end
      OPW'(19): begin b.j = 1'b1; b.mode_sel = 2'd0; b.b_sel = '0; b.const_in = imm; end
      OPW'(20): begin b.j = 1'b1; b.mode_sel = 2'd1; b.b_sel = '0; b.const_in = imm; end
      OPW'(21): begin
        b.j = 1'b1; b.mode_sel = 2'd2; b.offset_sel = 1'b1; b.b_sel = '0; b.const_in = imm;
      end
      default: begin
        b         = '0;
        b.illegal = 1'b1;
      end
    endcase
    return b;
  endfunction

  function automatic logic reads_a(input logic [OPW-1:0] op);
    return (op >= OPW'(1)) && (op <= OPW'(18));
  endfunction

  function automatic logic reads_b(input logic [OPW-1:0] op);
    case (op)
      OPW'(2), OPW'(3), OPW'(4), OPW'(5), OPW'(6), OPW'(7),
      OPW'(13), OPW'(14), OPW'(15), OPW'(17): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  bundle_t         bundle_q, bundle_d, dec_in;
  logic            out_valid_q, out_valid_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [RA_W-1:0] ld_reg_q, ld_reg_d;
  logic [OPW-1:0]  op_in;
  logic            held_ld, a_hit, b_hit, stall, accept, out_fire, squash;
  logic            unused_instr_lo;

  assign unused_instr_lo = ^instr[B_MSB-CW:0];

  assign op_in  = instr[IW-1 -: OPW];
  assign dec_in = decode(instr);
  // data_sel is set only by ld, so it doubles as the "held word is a load" marker
  assign held_ld = out_valid_q && bundle_q.data_sel;

  always_comb begin
    a_hit = reads_a(op_in) && (dec_in.a_sel != '0) &&
            ((held_ld && (bundle_q.dest_sel == dec_in.a_sel)) ||
             ((ld_cnt_q != '0) && (ld_reg_q == dec_in.a_sel)));
    b_hit = reads_b(op_in) && (dec_in.b_sel != '0) &&
            ((held_ld && (bundle_q.dest_sel == dec_in.b_sel)) ||
             ((ld_cnt_q != '0) && (ld_reg_q == dec_in.b_sel)));
    stall = (LD_BUBBLES > 0) && (a_hit || b_hit);
  end

  assign in_ready = !rst && !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

`ifdef DECODE_BR_SQUASH_EN
  localparam int SH_W = (BR_SHADOW > 1) ? $clog2(BR_SHADOW + 1) : 1;
  logic [SH_W-1:0] shadow_cnt_q, shadow_cnt_d, shadow_base;

  // a jump leaving this cycle already shadows a word accepted in the same cycle
  always_comb begin
    shadow_base  = (out_fire && bundle_q.j) ? SH_W'(BR_SHADOW) : shadow_cnt_q;
    squash       = accept && (shadow_base != '0);
    shadow_cnt_d = squash ? shadow_base - SH_W'(1) : shadow_base;
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_cnt_q <= '0;
    else     shadow_cnt_q <= shadow_cnt_d;
  end
`else
  localparam int unused_br_shadow = BR_SHADOW;
  assign squash = 1'b0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (accept && !squash) begin
      out_valid_d = 1'b1;
      bundle_d    = dec_in;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    ld_cnt_d = ld_cnt_q;
    ld_reg_d = ld_reg_q;
    if (out_fire && bundle_q.data_sel && (bundle_q.dest_sel != '0)) begin
      ld_cnt_d = CNT_W'(LD_BUBBLES);
      ld_reg_d = bundle_q.dest_sel;
    end else if (ld_cnt_q != '0) begin
      ld_cnt_d = ld_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      ld_cnt_q    <= '0;
      ld_reg_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_reg_q    <= ld_reg_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_sel   = bundle_q.data_sel;
  assign const_sel  = bundle_q.const_sel;
  assign load_en    = bundle_q.load_en;
  assign offset_sel = bundle_q.offset_sel;
  assign J          = bundle_q.j;
  assign write_en   = bundle_q.write_en;
  assign illegal    = bundle_q.illegal;
  assign const_in   = bundle_q.const_in;
  assign dest_sel   = bundle_q.dest_sel;
  assign A_sel      = bundle_q.a_sel;
  assign B_sel      = bundle_q.b_sel;
  assign op_sel     = bundle_q.op_sel;
  assign mode_sel   = bundle_q.mode_sel;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized stream
// scored against a transaction-level model of the decode table and interlock rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid;
  logic        data_sel, const_sel, load_en, offset_sel, J, write_en, illegal;
  logic [15:0] const_in;
  logic [3:0]  dest_sel, A_sel, B_sel, op_sel;
  logic [1:0]  mode_sel;
  logic [40:0] got;

`ifdef DECODE_BR_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  localparam int LDB = 1;
  localparam int SHD = 1;

  int nchk = 0;
  int nerr = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_sel(data_sel), .const_sel(const_sel), .load_en(load_en), .offset_sel(offset_sel),
    .J(J), .write_en(write_en), .illegal(illegal), .const_in(const_in),
    .dest_sel(dest_sel), .A_sel(A_sel), .B_sel(B_sel), .op_sel(op_sel), .mode_sel(mode_sel)
  );

  always #5 clk = ~clk;

  assign got = {illegal, data_sel, const_sel, load_en, offset_sel, J, write_en,
                const_in, dest_sel, A_sel, B_sel, op_sel, mode_sel};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input int op, input int d, input int a, input int b);
    return {5'(op), 4'(d), 4'(a), 4'(b), 15'd0};
  endfunction

  function automatic logic [31:0] mk_imm(input int op, input int d, input int a, input int imm);
    return {5'(op), 4'(d), 4'(a), 16'(imm), 3'd0};
  endfunction

  // Expected output bundle straight from the decode table.
  function automatic logic [40:0] model(input logic [31:0] w);
    int op;
    logic [3:0] d, a, b, alu;
    logic [15:0] imm, ci;
    logic il, ds, cs, le, os, j, we;
    logic [1:0] ms;
    op = int'(w[31:27]);
    d = w[26:23]; a = w[22:19]; b = w[18:15]; imm = w[18:3];
    {il, ds, cs, le, os, j, we} = 7'b0;
    ci = 16'h0; alu = 4'h0; ms = 2'd0;
    if (op >= 22) begin il = 1'b1; d = 4'h0; a = 4'h0; b = 4'h0; end
    else if (op == 1) begin le = 1'b1; cs = 1'b1; alu = 4'd5; end
    else if (op >= 2 && op <= 7) begin le = 1'b1; alu = 4'(op < 4 ? op - 2 : op); end
    else if (op >= 8 && op <= 12) begin
      le = 1'b1; cs = 1'b1; b = 4'h0; ci = imm; alu = 4'(op < 10 ? op - 8 : op - 6);
    end
    else if (op == 13) begin le = 1'b1; cs = 1'b1; b = d; alu = 4'd5; end
    else if (op == 14) begin le = 1'b1; alu = 4'd9; end
    else if (op == 15) begin le = 1'b1; alu = 4'd8; end
    else if (op == 16) begin le = 1'b1; ds = 1'b1; b = 4'h0; end
    else if (op == 17) begin we = 1'b1; d = 4'h0; end
    else if (op == 18) begin j = 1'b1; ms = 2'd3; os = 1'b1; d = 4'h0; b = 4'h0; end
    else if (op >= 19) begin j = 1'b1; b = 4'h0; ci = imm; ms = 2'(op - 19); os = (op == 21); end
    return {il, ds, cs, le, os, j, we, ci, d, a, b, alu, ms};
  endfunction

  function automatic bit reads_reg(input logic [31:0] w, input logic [3:0] r);
    int op;
    bit ra, rb;
    logic [3:0] breg;
    op   = int'(w[31:27]);
    ra   = (op >= 1 && op <= 18);
    rb   = (op >= 2 && op <= 7) || (op >= 13 && op <= 15) || (op == 17);
    breg = (op == 13) ? w[26:23] : w[18:15];
    return (r != 4'h0) && ((ra && w[22:19] == r) || (rb && breg == r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = mk(2, 3, 1, 2);
    tick(); tick();
    #1;
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    nchk++; if (got !== 41'h0) begin nerr++; $display("FAIL reset_bundle got=%h exp=0", got); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_add();
    in_valid = 1'b1; instr = mk(2, 3, 1, 2); out_ready = 1'b1;
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    nchk++;
    if (got !== {7'b0001000, 16'h0, 4'd3, 4'd1, 4'd2, 4'd0, 2'd0}) begin
      nerr++; $display("FAIL add_bundle got=%h exp=%h", got, {7'b0001000, 16'h0, 4'd3, 4'd1, 4'd2, 4'd0, 2'd0});
    end
    tick();
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_adi_illegal();
    in_valid = 1'b1; instr = mk_imm(8, 4, 4, 16'h1234); out_ready = 1'b1;
    tick();
    nchk++;
    if (got !== {7'b0011000, 16'h1234, 4'd4, 4'd4, 4'd0, 4'd0, 2'd0}) begin
      nerr++; $display("FAIL adi_bundle got=%h exp=%h", got, {7'b0011000, 16'h1234, 4'd4, 4'd4, 4'd0, 4'd0, 2'd0});
    end
    instr = mk(23, 5, 6, 7);
    tick();
    in_valid = 1'b0;
    nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL illegal_valid got=%b exp=1", out_valid); end
    nchk++;
    if (got !== {7'b1000000, 34'h0}) begin
      nerr++; $display("FAIL illegal_bundle got=%h exp=%h", got, {7'b1000000, 34'h0});
    end
    tick();
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL illegal_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    logic [31:0] ldw, addw;
    ldw = mk(16, 5, 0, 0); addw = mk(2, 7, 5, 1);
    out_ready = 1'b1; in_valid = 1'b1; instr = ldw;
    tick();
    nchk++; if (got !== model(ldw)) begin nerr++; $display("FAIL ld_bundle got=%h exp=%h", got, model(ldw)); end
    instr = addw;
    #1;
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL lu_stall_held got=%b exp=0", in_ready); end
    tick();
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL lu_gap_valid got=%b exp=0", out_valid); end
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL lu_stall_bubble got=%b exp=0", in_ready); end
    tick();
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL lu_release got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL lu_add_valid got=%b exp=1", out_valid); end
    nchk++; if (got !== model(addw)) begin nerr++; $display("FAIL lu_add_bundle got=%h exp=%h", got, model(addw)); end
    tick();
    addw = mk(2, 7, 6, 1);
    in_valid = 1'b1; instr = ldw;
    tick();
    instr = addw;
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL nodep_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL nodep_valid got=%b exp=1", out_valid); end
    nchk++; if (got !== model(addw)) begin nerr++; $display("FAIL nodep_bundle got=%h exp=%h", got, model(addw)); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] subw, xorw;
    subw = mk(3, 2, 1, 3); xorw = mk(6, 8, 9, 10);
    in_valid = 1'b1; instr = subw; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; instr = xorw;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
      nchk++;
      if (out_valid !== 1'b1 || got !== model(subw)) begin
        nerr++; $display("FAIL bp_hold[%0d] valid=%b got=%h exp=%h", i, out_valid, got, model(subw));
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || got !== model(xorw)) begin
      nerr++; $display("FAIL bp_next valid=%b got=%h exp=%h", out_valid, got, model(xorw));
    end
    tick();
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_branch_squash();
    logic [31:0] words[3];
    logic [40:0] seen[$];
    logic [40:0] exp_q[$];
    words[0] = mk_imm(21, 0, 0, 16'h0040);
    words[1] = mk(2, 1, 2, 3);
    words[2] = mk(5, 4, 5, 6);
    exp_q.push_back({7'b0000110, 16'h0040, 12'h0, 4'd0, 2'd2});
    if (!SQ) exp_q.push_back(model(words[1]));
    exp_q.push_back(model(words[2]));
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3);
      if (c < 3) instr = words[c];
      #1;
      if (c < 3) begin
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL br_ready[%0d] got=%b exp=1", c, in_ready); end
      end
      if (out_valid === 1'b1) seen.push_back(got);
      tick();
    end
    in_valid = 1'b0;
    nchk++;
    if (seen.size() != exp_q.size()) begin
      nerr++; $display("FAIL br_count got=%0d exp=%0d", seen.size(), exp_q.size());
    end
    for (int i = 0; i < seen.size() && i < exp_q.size(); i++) begin
      nchk++;
      if (seen[i] !== exp_q[i]) begin nerr++; $display("FAIL br_out[%0d] got=%h exp=%h", i, seen[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] addw;
    addw = mk(2, 3, 10, 9);
    out_ready = 1'b1; in_valid = 1'b1; instr = mk(16, 9, 0, 0);
    tick();
    instr = mk(16, 10, 0, 0);
    tick();
    out_ready = 1'b0; in_valid = 1'b0; rst = 1'b1;
    #1;
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rmid_ready got=%b exp=0", in_ready); end
    tick();
    rst = 1'b0;
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    nchk++; if (got !== 41'h0) begin nerr++; $display("FAIL rmid_bundle got=%h exp=0", got); end
    in_valid = 1'b1; instr = addw;
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rmid_dep_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || got !== model(addw)) begin
      nerr++; $display("FAIL rmid_dep_out valid=%b got=%h exp=%h", out_valid, got, model(addw));
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] w;
    logic [3:0]  ld_r;
    int          ld_left, sh, op;
    bit          stall, exp_rdy, fire, acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    ld_left = 0; ld_r = 4'h0; sh = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      nchk++;
      if (out_valid !== (q.size() != 0)) begin
        nerr++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, out_valid, q.size() != 0);
      end
      op = $urandom_range(0, 9);
      if (op < 3) op = 16;
      else if (op == 3) op = $urandom_range(22, 31);
      else if (op == 4) op = $urandom_range(18, 21);
      else op = $urandom_range(0, 17);
      w = $urandom;
      w[31:15] = {5'(op), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      instr = w;
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      stall = (q.size() != 0 && q[0][31:27] == 5'd16 && reads_reg(instr, q[0][26:23])) ||
              (ld_left > 0 && reads_reg(instr, ld_r));
      exp_rdy = !stall && (q.size() == 0 || out_ready);
      nchk++;
      if (in_ready !== exp_rdy) begin nerr++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, in_ready, exp_rdy); end
      fire = (q.size() != 0) && out_ready;
      w = 32'h0;
      if (fire) begin
        nchk++;
        if (got !== model(q[0])) begin nerr++; $display("FAIL rnd_bundle[%0d] got=%h exp=%h", cyc, got, model(q[0])); end
        w = q.pop_front();
      end
      if (fire && w[31:27] == 5'd16 && w[26:23] != 4'h0) begin ld_left = LDB; ld_r = w[26:23]; end
      else if (ld_left > 0) ld_left--;
      if (SQ && fire && w[31:27] >= 5'd18 && w[31:27] <= 5'd21) sh = SHD;
      acc = in_valid && exp_rdy;
      if (acc) begin
        if (sh > 0) sh--;
        else q.push_back(instr);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    test_reset();
    test_add();
    test_adi_illegal();
    test_load_use();
    test_backpressure();
    test_branch_squash();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
